// File: rtl/sprite_overlay.sv
// ============================================================================
// Module      : sprite_overlay
// Description : Two-stage pixel pipeline that draws one bouncing solid sprite
//               over the incoming background colour. Optional macro
//               SPRITE_BORDER_EN draws a white 1-pixel ring around the sprite.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sprite_overlay #(
  parameter int          HACT      = 640,
  parameter int          VACT      = 480,
  parameter int          SPR_W     = 32,
  parameter int          SPR_H     = 32,
  parameter int          STEP      = 2,
  parameter logic [23:0] SPR_COLOR = 24'hFFFF00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic        picture,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  bg_r,
  input  logic [7:0]  bg_g,
  input  logic [7:0]  bg_b,
  input  logic        move_en,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [7:0]  frame_cnt
);

  localparam logic [11:0] c_hact   = 12'(HACT);
  localparam logic [11:0] c_vact   = 12'(VACT);
  localparam logic [11:0] c_spr_w  = 12'(SPR_W);
  localparam logic [11:0] c_spr_h  = 12'(SPR_H);
  localparam logic [11:0] c_step   = 12'(STEP);
  localparam logic [23:0] c_border = 24'hFFFFFF;

  // Returns {new_dir, new_pos[10:0]}; 12-bit arithmetic keeps the sum clear of overflow.
  function automatic logic [11:0] axis_next(
    input logic [10:0] pos,
    input logic        dir,
    input logic [11:0] lim,
    input logic [11:0] size
  );
    logic [11:0] p;
    logic [11:0] lim_pos;
    p       = {1'b0, pos};
    lim_pos = lim - size;
    axis_next = {dir, pos};
    if (!dir) begin
      if (p + c_step + size > lim) axis_next = {1'b1, lim_pos[10:0]};
      else                         axis_next = {1'b0, 11'(p + c_step)};
    end else begin
      if (p < c_step) axis_next = {1'b0, 11'd0};
      else            axis_next = {1'b1, 11'(p - c_step)};
    end
  endfunction

  logic [10:0] r_spr_x, r_spr_y;
  logic        r_dir_x, r_dir_y;
  logic        r_vs_d;
  logic [7:0]  r_frame_cnt;
  logic        w_tick;
  logic [11:0] w_x_nxt, w_y_nxt;

  assign w_tick  = vsync & ~r_vs_d;
  assign w_x_nxt = axis_next(r_spr_x, r_dir_x, c_hact, c_spr_w);
  assign w_y_nxt = axis_next(r_spr_y, r_dir_y, c_vact, c_spr_h);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d      <= 1'b0;
      r_frame_cnt <= 8'd0;
      r_spr_x     <= 11'd0;
      r_spr_y     <= 11'd0;
      r_dir_x     <= 1'b0;
      r_dir_y     <= 1'b0;
    end else begin
      r_vs_d <= vsync;
      if (w_tick) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
        if (move_en) begin
          r_dir_x <= w_x_nxt[11];
          r_spr_x <= w_x_nxt[10:0];
          r_dir_y <= w_y_nxt[11];
          r_spr_y <= w_y_nxt[10:0];
        end
      end
    end
  end

  // Stage 1: sprite hit test against the current raster position
  logic [11:0] w_h, w_v, w_x0, w_y0, w_x1, w_y1;
  logic        w_inside, w_ring;

  assign w_h      = {1'b0, hcount};
  assign w_v      = {1'b0, vcount};
  assign w_x0     = {1'b0, r_spr_x};
  assign w_y0     = {1'b0, r_spr_y};
  assign w_x1     = w_x0 + c_spr_w;
  assign w_y1     = w_y0 + c_spr_h;
  assign w_inside = (w_h >= w_x0) && (w_h < w_x1) && (w_v >= w_y0) && (w_v < w_y1);
`ifdef SPRITE_BORDER_EN
  assign w_ring   = w_inside && ((w_h == w_x0) || (w_h == w_x1 - 12'd1) ||
                                 (w_v == w_y0) || (w_v == w_y1 - 12'd1));
`else
  assign w_ring   = 1'b0;
`endif

  logic        r_inside_d1, r_ring_d1, r_de_d1, r_hs_d1, r_vs_d1;
  logic [23:0] r_bg_d1;
  logic [23:0] r_rgb;
  logic        r_de_d2, r_hs_d2, r_vs_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inside_d1 <= 1'b0;
      r_ring_d1   <= 1'b0;
      r_de_d1     <= 1'b0;
      r_hs_d1     <= 1'b0;
      r_vs_d1     <= 1'b0;
      r_bg_d1     <= 24'd0;
    end else begin
      r_inside_d1 <= w_inside;
      r_ring_d1   <= w_ring;
      r_de_d1     <= picture;
      r_hs_d1     <= hsync;
      r_vs_d1     <= vsync;
      r_bg_d1     <= {bg_r, bg_g, bg_b};
    end
  end

  // Stage 2: colour select, blanked outside active video
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb   <= 24'd0;
      r_de_d2 <= 1'b0;
      r_hs_d2 <= 1'b0;
      r_vs_d2 <= 1'b0;
    end else begin
      r_de_d2 <= r_de_d1;
      r_hs_d2 <= r_hs_d1;
      r_vs_d2 <= r_vs_d1;
      if (!r_de_d1)         r_rgb <= 24'd0;
      else if (r_ring_d1)   r_rgb <= c_border;
      else if (r_inside_d1) r_rgb <= SPR_COLOR;
      else                  r_rgb <= r_bg_d1;
    end
  end

  assign red       = r_rgb[23:16];
  assign green     = r_rgb[15:8];
  assign blue      = r_rgb[7:0];
  assign de_o      = r_de_d2;
  assign hsync_o   = r_hs_d2;
  assign vsync_o   = r_vs_d2;
  assign frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sprite_overlay.sv
// ============================================================================
// Module      : tb_sprite_overlay
// Description : Scoreboard bench for sprite_overlay (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sprite_overlay;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount, vcount;
  logic        picture, hsync, vsync, move_en;
  logic [7:0]  bg_r, bg_g, bg_b;
  logic [7:0]  red, green, blue, frame_cnt;
  logic        de_o, hsync_o, vsync_o;

  sprite_overlay dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .picture(picture), .hsync(hsync), .vsync(vsync),
    .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b), .move_en(move_en),
    .red(red), .green(green), .blue(blue),
    .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint      cyc;
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t   q[$];
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;
  logic [7:0] exp_frame = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the entry due on this cycle and compares all outputs
  always @(posedge clk) begin
    #1;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL pix_missed: expected entry for cycle %0d not seen", q[0].cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ({red, green, blue} !== e.rgb || de_o !== e.de || hsync_o !== e.hs || vsync_o !== e.vs) begin
        errors++;
        $display("FAIL pix @cyc %0d: got rgb=%06h de=%b hs=%b vs=%b, want rgb=%06h de=%b hs=%b vs=%b",
                 cyc, {red, green, blue}, de_o, hsync_o, vsync_o, e.rgb, e.de, e.hs, e.vs);
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Drive one pixel and push its hand-derived response; sprite sits at (sx,sy)
  task automatic drive_px(input int h, input int v, input logic pic, input logic [23:0] bg,
                          input logic hs, input logic vs, input int sx, input int sy);
    exp_t e;
    logic in_spr, ring;
    @(negedge clk);
    hcount = 11'(h); vcount = 11'(v); picture = pic;
    hsync = hs; vsync = vs; {bg_r, bg_g, bg_b} = bg;
    in_spr = (h >= sx) && (h < sx + 32) && (v >= sy) && (v < sy + 32);
`ifdef SPRITE_BORDER_EN
    ring = in_spr && (h == sx || h == sx + 31 || v == sy || v == sy + 31);
`else
    ring = 1'b0;
`endif
    e.cyc = cyc + 2;
    e.rgb = !pic ? 24'h000000 : ring ? 24'hFFFFFF : in_spr ? 24'hFFFF00 : bg;
    e.de  = pic; e.hs = hs; e.vs = vs;
    q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    picture = 1'b0; hsync = 1'b0; vsync = 1'b0;
    hcount = 11'd0; vcount = 11'd0; {bg_r, bg_g, bg_b} = 24'd0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); vsync = 1'b1;
      @(negedge clk);
      @(negedge clk); vsync = 1'b0;
      @(negedge clk);
      exp_frame = exp_frame + 8'd1;
    end
  endtask

  task automatic chk_pos(input string tag, input int x, input int y, input int dx, input int dy);
    chk({tag, "_x"},     dut.r_spr_x, x);
    chk({tag, "_y"},     dut.r_spr_y, y);
    chk({tag, "_dir_x"}, dut.r_dir_x, dx);
    chk({tag, "_dir_y"}, dut.r_dir_y, dy);
    chk({tag, "_frame"}, frame_cnt, exp_frame);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; move_en = 1'b1;
    picture = 1'b0; hsync = 1'b0; vsync = 1'b0;
    hcount = 11'd0; vcount = 11'd0; {bg_r, bg_g, bg_b} = 24'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb",   {red, green, blue}, 0);
    chk("rst_sync",  {de_o, hsync_o, vsync_o}, 0);
    chk("rst_frame", frame_cnt, 0);
    @(negedge clk); rst_n = 1'b1;

    // Live pixels on the outputs, then reset mid-line
    @(negedge clk);
    hcount = 11'd300; vcount = 11'd300; picture = 1'b1; hsync = 1'b1;
    {bg_r, bg_g, bg_b} = 24'h808080;
    repeat (3) @(posedge clk);
    #3;
    chk("live_de", de_o, 1);
    chk("live_rgb", {red, green, blue}, 24'h808080);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rgb",  {red, green, blue}, 0);
    chk("async_rst_sync", {de_o, hsync_o, vsync_o}, 0);
    idle();
    @(negedge clk); rst_n = 1'b1;

    run_ticks(1);
    chk_pos("first", 2, 2, 0, 0);
    run_ticks(47);
    chk_pos("t48", 96, 96, 0, 0);

    // Sprite covers x 96..127, y 96..127
    for (int h = 95; h <= 128; h++) drive_px(h, 100, 1'b1, 24'h808080, h[1], 1'b0, 96, 96);
    for (int h = 100; h <= 101; h++) drive_px(h, 96, 1'b1, 24'h808080, 1'b1, 1'b0, 96, 96);
    for (int h = 127; h <= 128; h++) drive_px(h, 127, 1'b1, 24'h808080, 1'b0, 1'b0, 96, 96);
    for (int h = 100; h <= 103; h++) drive_px(h, 130, 1'b1, 24'h123456, 1'b0, 1'b0, 96, 96);
    for (int h = 100; h <= 103; h++) drive_px(h, 100, 1'b0, 24'h808080, 1'b1, 1'b0, 96, 96);
    idle();

    // vsync passthrough with movement frozen: two rising edges
    move_en = 1'b0;
    drive_px(10, 0, 1'b0, 24'h0, 1'b0, 1'b0, 96, 96);
    drive_px(11, 0, 1'b0, 24'h0, 1'b0, 1'b1, 96, 96);
    drive_px(12, 0, 1'b0, 24'h0, 1'b0, 1'b1, 96, 96);
    drive_px(13, 0, 1'b0, 24'h0, 1'b0, 1'b0, 96, 96);
    drive_px(14, 0, 1'b0, 24'h0, 1'b1, 1'b1, 96, 96);
    drive_px(15, 0, 1'b0, 24'h0, 1'b0, 1'b0, 96, 96);
    idle();
    exp_frame = exp_frame + 8'd2;
    repeat (3) @(negedge clk);
    chk_pos("vs_frozen", 96, 96, 0, 0);

    run_ticks(3);
    chk_pos("freeze", 96, 96, 0, 0);
    move_en = 1'b1;

    // Right bounce: 303 moves -> x 606; y already bounced off the bottom
    run_ticks(255);
    chk_pos("m303", 606, 292, 0, 1);
    run_ticks(1);
    chk_pos("m304", 608, 290, 0, 1);
    run_ticks(1);
    chk_pos("m305", 608, 288, 1, 1);
    run_ticks(1);
    chk_pos("m306", 606, 286, 1, 1);

    // Top clamp then left clamp
    run_ticks(143);
    chk_pos("m449", 320, 0, 1, 1);
    run_ticks(1);
    chk_pos("m450", 318, 0, 1, 0);
    run_ticks(1);
    chk_pos("m451", 316, 2, 1, 0);
    run_ticks(158);
    chk_pos("m609", 0, 318, 1, 0);
    run_ticks(1);
    chk_pos("m610", 0, 320, 0, 0);
    run_ticks(1);
    chk_pos("m611", 2, 322, 0, 0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
